// File: rtl/hive_params.sv
// Shared types and default widths for the Hive multiply / MAC unit.
package hive_params;

  localparam int unsigned MAC_IN_W  = 32;
  localparam int unsigned MAC_ACC_W = 72;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_MAC = 2'd1,
    OP_MSB = 2'd2,
    OP_LD  = 2'd3
  } mac_op_t;

endpackage

// File: rtl/hive_mul_core.sv
// Stages S0-S3: sign-mode-aware split multiplier with valid/op sideband.
// The operands are widened to IN_W+1 bits so one signed datapath covers all
// four sign-mode combinations; the split keeps each multiplier near half width.
module hive_mul_core
  import hive_params::*;
#(
  parameter int unsigned IN_W = MAC_IN_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   in_valid_i,
  input  logic [IN_W-1:0]        a_i,
  input  logic [IN_W-1:0]        b_i,
  input  logic                   a_sgn_i,
  input  logic                   b_sgn_i,
  input  mac_op_t                op_i,
  output logic                   valid_o,
  output mac_op_t                op_o,
  output logic signed [2*IN_W:0] p_o
);

  localparam int unsigned LO_W   = IN_W - IN_W / 2;
  localparam int unsigned HI_W   = IN_W + 1 - LO_W;
  localparam int unsigned HH_W   = 2 * HI_W;
  localparam int unsigned HL_W   = HI_W + LO_W + 1;
  localparam int unsigned CS_W   = HL_W + 1;
  localparam int unsigned LL_W   = 2 * LO_W;
  localparam int unsigned FULL_W = 2 * IN_W + 2;
  localparam int unsigned P_W    = 2 * IN_W + 1;

  logic                     s0_v_q, s0_v_d;
  mac_op_t                  s0_op_q, s0_op_d;
  logic signed [IN_W:0]     s0_a_q, s0_a_d, s0_b_q, s0_b_d;

  logic                     s1_v_q, s1_v_d;
  mac_op_t                  s1_op_q, s1_op_d;
  logic signed [HH_W-1:0]   s1_hh_q, s1_hh_d;
  logic signed [HL_W-1:0]   s1_hl_q, s1_hl_d, s1_lh_q, s1_lh_d;
  logic [LL_W-1:0]          s1_ll_q, s1_ll_d;

  logic                     s2_v_q, s2_v_d;
  mac_op_t                  s2_op_q, s2_op_d;
  logic signed [FULL_W-1:0] s2_inner_q, s2_inner_d, s2_outer_q, s2_outer_d;

  logic                     s3_v_q, s3_v_d;
  mac_op_t                  s3_op_q, s3_op_d;
  logic signed [P_W-1:0]    s3_p_q, s3_p_d;

  logic signed [HI_W-1:0]   a_hi, b_hi;
  logic [LO_W-1:0]          a_lo, b_lo;
  logic signed [LO_W:0]     a_lo_s, b_lo_s;
  logic signed [CS_W-1:0]   cross_sum;

  // Split the widened operands: signed high halves, zero-extended low halves.
  assign a_hi      = s0_a_q[IN_W:LO_W];
  assign b_hi      = s0_b_q[IN_W:LO_W];
  assign a_lo      = s0_a_q[LO_W-1:0];
  assign b_lo      = s0_b_q[LO_W-1:0];
  assign a_lo_s    = {1'b0, a_lo};
  assign b_lo_s    = {1'b0, b_lo};
  assign cross_sum = CS_W'(s1_hl_q) + CS_W'(s1_lh_q);

  // Next-state for all four stages; everything holds while en_i is low.
  always_comb begin
    s0_v_d = s0_v_q;  s0_op_d = s0_op_q;  s0_a_d = s0_a_q;  s0_b_d = s0_b_q;
    s1_v_d = s1_v_q;  s1_op_d = s1_op_q;  s1_hh_d = s1_hh_q;
    s1_hl_d = s1_hl_q;  s1_lh_d = s1_lh_q;  s1_ll_d = s1_ll_q;
    s2_v_d = s2_v_q;  s2_op_d = s2_op_q;
    s2_inner_d = s2_inner_q;  s2_outer_d = s2_outer_q;
    s3_v_d = s3_v_q;  s3_op_d = s3_op_q;  s3_p_d = s3_p_q;
    if (en_i) begin
      s0_v_d     = in_valid_i;
      s0_op_d    = op_i;
      s0_a_d     = {a_sgn_i & a_i[IN_W-1], a_i};
      s0_b_d     = {b_sgn_i & b_i[IN_W-1], b_i};

      s1_v_d     = s0_v_q;
      s1_op_d    = s0_op_q;
      s1_hh_d    = HH_W'(a_hi) * HH_W'(b_hi);
      s1_hl_d    = HL_W'(a_hi) * HL_W'(b_lo_s);
      s1_lh_d    = HL_W'(a_lo_s) * HL_W'(b_hi);
      s1_ll_d    = LL_W'(a_lo) * LL_W'(b_lo);

      s2_v_d     = s1_v_q;
      s2_op_d    = s1_op_q;
      s2_inner_d = FULL_W'(cross_sum) << LO_W;
      s2_outer_d = {s1_hh_q, s1_ll_q};

      s3_v_d     = s2_v_q;
      s3_op_d    = s2_op_q;
      s3_p_d     = P_W'(s2_outer_q + s2_inner_q);
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s0_v_q <= 1'b0;  s0_op_q <= OP_MUL;  s0_a_q <= '0;  s0_b_q <= '0;
      s1_v_q <= 1'b0;  s1_op_q <= OP_MUL;  s1_hh_q <= '0;
      s1_hl_q <= '0;  s1_lh_q <= '0;  s1_ll_q <= '0;
      s2_v_q <= 1'b0;  s2_op_q <= OP_MUL;  s2_inner_q <= '0;  s2_outer_q <= '0;
      s3_v_q <= 1'b0;  s3_op_q <= OP_MUL;  s3_p_q <= '0;
    end else begin
      s0_v_q <= s0_v_d;  s0_op_q <= s0_op_d;  s0_a_q <= s0_a_d;  s0_b_q <= s0_b_d;
      s1_v_q <= s1_v_d;  s1_op_q <= s1_op_d;  s1_hh_q <= s1_hh_d;
      s1_hl_q <= s1_hl_d;  s1_lh_q <= s1_lh_d;  s1_ll_q <= s1_ll_d;
      s2_v_q <= s2_v_d;  s2_op_q <= s2_op_d;
      s2_inner_q <= s2_inner_d;  s2_outer_q <= s2_outer_d;
      s3_v_q <= s3_v_d;  s3_op_q <= s3_op_d;  s3_p_q <= s3_p_d;
    end
  end

  assign valid_o = s3_v_q;
  assign op_o    = s3_op_q;
  assign p_o     = s3_p_q;

endmodule

// File: rtl/hive_pipe.sv
// Enable-gated delay line: DEPTH registers of width W, all advancing together.
module hive_pipe #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stg_q [DEPTH];
  logic [W-1:0] stg_d [DEPTH];

  // Shift one position per enabled cycle, otherwise hold.
  always_comb begin
    stg_d = stg_q;
    if (en_i) begin
      stg_d[0] = d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  // Delay registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      stg_q <= stg_d;
    end
  end

  assign q_o = stg_q[DEPTH-1];

endmodule

// File: rtl/hive_alu_mac.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready handshake.
// A single global advance stalls the whole pipe, so beats cannot reorder;
// the accumulator lives only in S4, so back-to-back MACs need no forwarding.
module hive_alu_mac
  import hive_params::*;
#(
  parameter int unsigned IN_W       = MAC_IN_W,
  parameter int unsigned ACC_W      = MAC_ACC_W,
  parameter int unsigned DEBUG_MODE = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  input  logic              a_sgn_i,
  input  logic              b_sgn_i,
  input  logic [1:0]        op_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*IN_W-1:0] result_o,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o,
  output logic              debug_o
);

  localparam int unsigned P_W = 2 * IN_W + 1;

  if (ACC_W < P_W) begin : g_bad_acc_w
    $error("hive_alu_mac: ACC_W must be at least 2*IN_W+1");
  end

  logic                  adv;
  logic                  core_v;
  mac_op_t               core_op;
  logic signed [P_W-1:0] core_p;

  logic                  out_valid_q, out_valid_d;
  logic [2*IN_W-1:0]     result_q, result_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_W-1:0]      px, acc_sum, acc_diff;
  logic                  mac_ovf, msb_ovf;

  assign adv        = !out_valid_q || out_ready_i;
  assign in_ready_o = adv;

  hive_mul_core #(.IN_W(IN_W)) u_core (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (adv),
    .in_valid_i (in_valid_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .a_sgn_i    (a_sgn_i),
    .b_sgn_i    (b_sgn_i),
    .op_i       (mac_op_t'(op_i)),
    .valid_o    (core_v),
    .op_o       (core_op),
    .p_o        (core_p)
  );

  // S4: accumulator update and signed-overflow detection for MAC/MSB.
  always_comb begin
    px       = ACC_W'(core_p);
    acc_sum  = acc_q + px;
    acc_diff = acc_q - px;
    mac_ovf  = (acc_q[ACC_W-1] == px[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    msb_ovf  = (acc_q[ACC_W-1] != px[ACC_W-1]) && (acc_diff[ACC_W-1] != acc_q[ACC_W-1]);

    out_valid_d = out_valid_q;
    result_d    = result_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = core_v;
      if (core_v) begin
        result_d = core_p[2*IN_W-1:0];
        case (core_op)
          OP_MUL: ;
          OP_MAC: begin
            acc_d = acc_sum;
            ovf_d = ovf_q | mac_ovf;
          end
          OP_MSB: begin
            acc_d = acc_diff;
            ovf_d = ovf_q | msb_ovf;
          end
          OP_LD: begin
            acc_d = px;
            ovf_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Output and accumulator registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign acc_o       = acc_q;
  assign ovf_o       = ovf_q;

  if (DEBUG_MODE != 0) begin : g_dbg
    logic signed [IN_W:0]  a_ext, b_ext;
    logic signed [P_W-1:0] native, native_s3;
    logic                  debug_q, debug_d;

    assign a_ext  = {a_sgn_i & a_i[IN_W-1], a_i};
    assign b_ext  = {b_sgn_i & b_i[IN_W-1], b_i};
    assign native = P_W'(a_ext) * P_W'(b_ext);

    hive_pipe #(.W(P_W), .DEPTH(4)) u_pipe (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (adv),
      .d_i     (native),
      .q_o     (native_s3)
    );

    // Compare the split product with the native one as the beat leaves S3.
    always_comb begin
      debug_d = debug_q;
      if (adv && core_v) begin
        debug_d = (core_p != native_s3);
      end
    end

    // Registered so the flag lines up with out_valid_o.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        debug_q <= 1'b0;
      end else begin
        debug_q <= debug_d;
      end
    end

    assign debug_o = debug_q;
  end else begin : g_no_dbg
    assign debug_o = 1'b0;
  end

endmodule

// File: tb/tb_hive_alu_mac.sv
// Bench for hive_alu_mac: a 72-bit and a 65-bit accumulator build share stimulus
// and are checked against an arithmetic reference model every cycle.
module tb_hive_alu_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;
  logic        as, bs;
  logic [1:0]  op;

  logic        in_ready, in_ready65;
  logic        ov, ov65;
  logic [63:0] res, res65;
  logic [71:0] acc;
  logic [64:0] acc65;
  logic        ovf, ovf65;
  logic        dbg, dbg65;

  always #5 clk = ~clk;

  hive_alu_mac #(.IN_W(32), .ACC_W(72), .DEBUG_MODE(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .a_sgn_i(as), .b_sgn_i(bs), .op_i(op),
    .out_valid_o(ov), .out_ready_i(out_ready), .result_o(res),
    .acc_o(acc), .ovf_o(ovf), .debug_o(dbg)
  );

  hive_alu_mac #(.IN_W(32), .ACC_W(65), .DEBUG_MODE(1)) dut65 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready65),
    .a_i(a), .b_i(b), .a_sgn_i(as), .b_sgn_i(bs), .op_i(op),
    .out_valid_o(ov65), .out_ready_i(out_ready), .result_o(res65),
    .acc_o(acc65), .ovf_o(ovf65), .debug_o(dbg65)
  );

  typedef struct {
    logic [63:0]         res;
    logic signed [127:0] acc72;
    logic signed [127:0] acc65;
    bit                  ovf72;
    bit                  ovf65;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t                q[$];
  bit                  slot_v[5];
  logic signed [127:0] m_acc72, m_acc65, sh_acc72, sh_acc65;
  bit                  m_ovf72, m_ovf65, sh_ovf72, sh_ovf65;
  int                  stall_left = 0;
  bit                  rand_ready = 1'b0;
  int                  obs_count = 0;
  int                  last_tries = 0;

  task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] wrapw(input logic signed [127:0] x, input int w);
    logic signed [127:0] t;
    t = x <<< (128 - w);
    return t >>> (128 - w);
  endfunction

  task automatic apply(inout logic signed [127:0] m, inout bit f, input int w,
                       input logic [1:0] o, input logic signed [127:0] p);
    logic signed [127:0] exact;
    case (o)
      2'd1:    exact = m + p;
      2'd2:    exact = m - p;
      2'd3:    exact = p;
      default: exact = m;
    endcase
    if ((o == 2'd1 || o == 2'd2) && wrapw(exact, w) != exact) f = 1'b1;
    if (o == 2'd3) f = 1'b0;
    m = wrapw(exact, w);
  endtask

  task automatic model_accept();
    logic signed [127:0] av, bv, p;
    exp_t e;
    av = as ? {{96{a[31]}}, a} : {96'd0, a};
    bv = bs ? {{96{b[31]}}, b} : {96'd0, b};
    p  = av * bv;
    apply(m_acc72, m_ovf72, 72, op, p);
    apply(m_acc65, m_ovf65, 65, op, p);
    e.res   = p[63:0];
    e.acc72 = m_acc72;
    e.acc65 = m_acc65;
    e.ovf72 = m_ovf72;
    e.ovf65 = m_ovf65;
    q.push_back(e);
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 5; i++) slot_v[i] = 1'b0;
    m_acc72 = '0;  m_acc65 = '0;  m_ovf72 = 1'b0;  m_ovf65 = 1'b0;
    sh_acc72 = '0; sh_acc65 = '0; sh_ovf72 = 1'b0; sh_ovf65 = 1'b0;
  endtask

  // One clock: drive ready, check handshake, advance the model, check outputs.
  task automatic tick(output bit accepted);
    bit adv;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    adv = !slot_v[4] || out_ready;
    chk(in_ready, adv, "in_ready");
    chk(in_ready65, adv, "in_ready65");
    accepted = rst_n && in_valid && adv;
    if (ov && out_ready && rst_n) obs_count++;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (adv) begin
      if (slot_v[4]) void'(q.pop_front());
      for (int i = 4; i > 0; i--) slot_v[i] = slot_v[i-1];
      slot_v[0] = accepted;
      if (accepted) model_accept();
    end
    if (slot_v[4] && q.size() > 0) begin
      sh_acc72 = q[0].acc72;  sh_acc65 = q[0].acc65;
      sh_ovf72 = q[0].ovf72;  sh_ovf65 = q[0].ovf65;
    end
    #1;
    chk(ov, slot_v[4], "out_valid");
    chk(ov65, slot_v[4], "out_valid65");
    chk(acc, sh_acc72[71:0], "acc72");
    chk(acc65, sh_acc65[64:0], "acc65");
    chk(ovf, sh_ovf72, "ovf72");
    chk(ovf65, sh_ovf65, "ovf65");
    chk(dbg, 1'b0, "debug72");
    chk(dbg65, 1'b0, "debug65");
    if (slot_v[4] && q.size() > 0) begin
      chk(res, q[0].res, "result72");
      chk(res65, q[0].res, "result65");
    end
  endtask

  task automatic beat(input logic [31:0] av, input logic [31:0] bv,
                      input bit sa, input bit sb, input logic [1:0] o);
    bit acc_ok;
    int n;
    n = 0;
    in_valid = 1'b1; a = av; b = bv; as = sa; bs = sb; op = o;
    do begin
      tick(acc_ok);
      n++;
    end while (!acc_ok && n < 50);
    last_tries = n;
    chk(acc_ok, 1'b1, "accept_bound");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc_ok;
    in_valid = 1'b0;
    repeat (n) tick(acc_ok);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc_ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; as = 1'b0; bs = 1'b0; op = 2'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk(ov, 1'b0, "reset_out_valid");
    chk(acc, 72'd0, "reset_acc");
    chk(ovf, 1'b0, "reset_ovf");
    chk(res, 64'd0, "reset_result");

    // Unsigned max squared with exact 5-cycle latency.
    beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0);
    idle(3);
    chk(ov, 1'b0, "latency_not_early");
    idle(1);
    chk(ov, 1'b1, "latency_5");
    chk(res, 64'hFFFF_FFFE_0000_0001, "umax_sq");
    chk(acc, 72'd0, "mul_keeps_acc");
    idle(2);

    // Sign modes.
    beat(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 2'd0);
    beat(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 2'd0);
    idle(3);
    chk(res, 64'h0000_0000_8000_0000, "ss_m1_min");
    idle(1);
    chk(res, 64'h8000_0000_8000_0000, "us_max_min");
    idle(4);

    // Back-to-back LD / MAC / MSB.
    beat(32'd3, 32'd4, 1'b0, 1'b0, 2'd3);
    beat(32'd5, 32'd6, 1'b1, 1'b1, 2'd1);
    beat(32'd2, 32'd2, 1'b0, 1'b1, 2'd2);
    idle(2);
    chk(acc, 72'd12, "seq_ld");
    idle(1);
    chk(acc, 72'd42, "seq_mac");
    idle(1);
    chk(acc, 72'd38, "seq_msb");
    chk(ovf, 1'b0, "seq_ovf");
    idle(4);

    // Backpressure: stall while the sixth beat is offered.
    obs_count = 0;
    for (int i = 0; i < 5; i++) beat(rand_operand(), rand_operand(), 1'b1, 1'b0, 2'd1);
    stall_left = 3;
    beat(rand_operand(), rand_operand(), 1'b0, 1'b1, 2'd1);
    chk(32'(last_tries), 32'd4, "stall_tries");
    idle(10);
    chk(32'(obs_count), 32'd6, "bp_beats_out");

    // Overflow on the 65-bit build.
    beat(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) beat(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 2'd1);
    idle(4);
    chk(acc65, 65'h1_0000_0000_0000_0000, "ovf65_wrap");
    chk(ovf65, 1'b1, "ovf65_set");
    chk(acc, 72'h01_0000_0000_0000_0000, "acc72_no_wrap");
    chk(ovf, 1'b0, "ovf72_clear");
    beat(32'd2, 32'd3, 1'b0, 1'b0, 2'd0);
    idle(5);
    chk(ovf65, 1'b1, "ovf65_sticky_mul");
    beat(32'd1, 32'd1, 1'b0, 1'b0, 2'd3);
    idle(4);
    chk(acc65, 65'd1, "ld_after_ovf");
    chk(ovf65, 1'b0, "ovf65_cleared_ld");

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++) beat(32'd7, 32'd7, 1'b0, 1'b0, 2'd1);
    rst_n = 1'b0;
    tick(acc_ok);
    rst_n = 1'b1;
    chk(ov, 1'b0, "rst_mid_valid");
    chk(acc, 72'd0, "rst_mid_acc");
    chk(ovf65, 1'b0, "rst_mid_ovf");
    idle(6);

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else
        idle(1);
    end
    rand_ready = 1'b0;
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
